uart_rx_fifo: RTL



---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_sync_fifo.sv | 70 +++++++
 rtl/uart_rx_fifo.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// UART shared definitions: parity modes and receiver FSM states.
// Shared between the RX path and the future TX block.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through FIFO with a registered head and occupancy level.
// A push into a full FIFO is accepted only together with a pop.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       din_i,
  output logic                   drop_o,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic                   valid_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q, rd_d;
  logic [LW-1:0]    lvl_q, lvl_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q;
  logic             full, do_push, do_pop;

  always_comb begin
    full    = (lvl_q == LW'(DEPTH));
    do_pop  = pop_i && valid_q;
    do_push = push_i && (!full || do_pop);
    drop_o  = push_i && !do_push;
    rd_d    = rd_q + AW'(do_pop);
    lvl_d   = lvl_q + LW'(do_push) - LW'(do_pop);
    head_d  = head_q;
    // Empty once the pop retires: incoming word becomes the head
    if (do_push && (lvl_q == LW'(do_pop))) begin
      head_d = din_i;
    end else if (do_pop && (lvl_q > LW'(1))) begin
      head_d = mem_q[rd_d];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= din_i;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q    <= '0;
      rd_q    <= '0;
      lvl_q   <= '0;
      head_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      wr_q    <= wr_q + AW'(do_push);
      rd_q    <= rd_d;
      lvl_q   <= lvl_d;
      head_q  <= head_d;
      valid_q <= (lvl_d != '0);
    end
  end

  assign dout_o  = head_q;
  assign valid_o = valid_q;
  assign level_o = lvl_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-flop synchroniser, centre-sampling FSM, error
// tagging, break detection and an FWFT receive FIFO.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUDRATE   = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        uart_rx,
  output logic [DATA_BITS-1:0]        rx_data,
  output logic                        rx_err_frame,
  output logic                        rx_err_parity,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] rx_level,
  output logic                        overrun,
  input  logic                        clr_overrun,
  output logic                        break_det
);

  localparam int DIV = CLK_HZ / BAUDRATE;
  localparam int CW  = $clog2(DIV) + 1;
  localparam int EW  = DATA_BITS + 2;
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(DIV - 1);
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);
  localparam logic LAST_STOP = (STOP_BITS == 2);

  if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("uart_rx_fifo: illegal parameter set");
  end

  logic                 meta_q, rxs_q;
  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 pbit_q, pbit_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 bwait_q, bwait_d;
  logic                 brk_q, brk_d;
  logic                 ovr_q;
  logic                 tick, ferr_n, pxor;
  logic                 push, drop;
  logic [EW-1:0]        head;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    sh_d    = sh_q;
    pbit_d  = pbit_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    bwait_d = bwait_q;
    brk_d   = 1'b0;
    push    = 1'b0;
    tick    = (cnt_q == '0);
    ferr_n  = ferr_q | ~rxs_q;
    pxor    = ^sh_q ^ rxs_q;
    if (state_q != ST_IDLE && !tick) begin
      cnt_d = cnt_q - 1'b1;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (!rxs_q) begin
          state_d = ST_START;
          cnt_d   = HALF;
        end
      end
      ST_START: begin
        if (tick) begin
          if (rxs_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
            cnt_d   = FULL;
            bit_d   = '0;
            stop_d  = 1'b0;
            pbit_d  = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          sh_d  = {rxs_q, sh_q[DATA_BITS-1:1]};
          cnt_d = FULL;
          bit_d = bit_q + 4'd1;
          if (bit_q == LAST_BIT) begin
            state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
          end
        end
      end
      ST_PAR: begin
        if (tick) begin
          pbit_d  = rxs_q;
          perr_d  = (PARITY == PAR_ODD) ? ~pxor : pxor;
          cnt_d   = FULL;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        // Break: hold here until the line returns high
        if (bwait_q) begin
          if (rxs_q) begin
            bwait_d = 1'b0;
            state_d = ST_IDLE;
          end
        end else if (tick) begin
          ferr_d = ferr_n;
          cnt_d  = FULL;
          if (stop_q == LAST_STOP) begin
            if (sh_q == '0 && !pbit_q && ferr_n) begin
              brk_d   = 1'b1;
              bwait_d = 1'b1;
            end else begin
              push    = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_q  <= 1'b1;
      rxs_q   <= 1'b1;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      sh_q    <= '0;
      pbit_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      bwait_q <= 1'b0;
      brk_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      meta_q  <= uart_rx;
      rxs_q   <= meta_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      sh_q    <= sh_d;
      pbit_q  <= pbit_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      bwait_q <= bwait_d;
      brk_q   <= brk_d;
      if (drop) begin
        ovr_q <= 1'b1;
      end else if (clr_overrun) begin
        ovr_q <= 1'b0;
      end
    end
  end

  uart_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (push),
    .din_i   ({sh_q, ferr_n, perr_q}),
    .drop_o  (drop),
    .pop_i   (rx_ready),
    .dout_o  (head),
    .valid_o (rx_valid),
    .level_o (rx_level)
  );

  assign {rx_data, rx_err_frame, rx_err_parity} = head;
  assign overrun   = ovr_q;
  assign break_det = brk_q;

endmodule
